// File: rtl/adc_packetizer.sv
// adc_packetizer: reads ADC bytes from a first-word-fall-through FIFO and
// frames them into packets for an Ethernet transmitter:
//   6-byte header (MAGIC, seq_num, PAYLOAD_LEN, each MSB first),
//   PAYLOAD_LEN payload bytes, then an enforced inter-packet gap.
// Optional feature macro: ADC_PKT_CHECKSUM_EN adds a TRAILER byte holding the
// XOR of all header and payload bytes; that byte then carries tx_last.
// Handshake: a byte moves when tx_valid & tx_rdy are both high on a rising
// clk edge; while tx_valid is high and tx_rdy low, tx_data and tx_last hold.
// dbg_state exposes the FSM state encoding for checkers.
module adc_packetizer #(
  parameter int unsigned PAYLOAD_LEN = 1024,
  parameter int unsigned IFG_CYCLES  = 16,
  parameter logic [15:0] MAGIC       = 16'hADC0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_empty,
  input  logic        fifo_full,
  output logic        fifo_rd_en,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_rdy,
  output logic        tx_last,
  output logic        pkt_active,
  output logic [15:0] seq_num,
  output logic        underrun,
  output logic [2:0]  dbg_state
);

`ifdef ADC_PKT_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_TRAILER = 3'd3,
    S_GAP     = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_GAP     = 3'd4
  } state_t;
`endif

  localparam logic [15:0] LEN16    = 16'(PAYLOAD_LEN);
  localparam logic [15:0] LAST_IDX = 16'(PAYLOAD_LEN - 1);
  localparam logic [7:0]  GAP_LAST = 8'(IFG_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  hdr_idx_q, hdr_idx_d;
  logic [15:0] pay_cnt_q, pay_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0] seq_q, seq_d;
  logic        underrun_q, underrun_d;
`ifdef ADC_PKT_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  assign seq_num   = seq_q;
  assign underrun  = underrun_q;
  assign dbg_state = state_q;

  // Next-state, counters and all handshake outputs; outputs are decoded from
  // the registered state so a reset forces them low immediately.
  always_comb begin
    state_d    = state_q;
    hdr_idx_d  = hdr_idx_q;
    pay_cnt_d  = pay_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    seq_d      = seq_q;
    underrun_d = underrun_q;
`ifdef ADC_PKT_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    tx_last    = 1'b0;
    fifo_rd_en = 1'b0;
    pkt_active = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable && fifo_full) begin
          state_d   = S_HEADER;
          hdr_idx_d = 3'd0;
          pay_cnt_d = 16'd0;
`ifdef ADC_PKT_CHECKSUM_EN
          csum_d    = 8'h00;
`endif
        end
      end

      S_HEADER: begin
        pkt_active = 1'b1;
        tx_valid   = 1'b1;
        case (hdr_idx_q)
          3'd0:    tx_data = MAGIC[15:8];
          3'd1:    tx_data = MAGIC[7:0];
          3'd2:    tx_data = seq_q[15:8];
          3'd3:    tx_data = seq_q[7:0];
          3'd4:    tx_data = LEN16[15:8];
          default: tx_data = LEN16[7:0];
        endcase
        if (tx_rdy) begin
`ifdef ADC_PKT_CHECKSUM_EN
          csum_d = csum_q ^ tx_data;
`endif
          if (hdr_idx_q == 3'd5) begin
            state_d   = S_PAYLOAD;
            hdr_idx_d = 3'd0;
          end else begin
            hdr_idx_d = hdr_idx_q + 3'd1;
          end
        end
      end

      S_PAYLOAD: begin
        pkt_active = 1'b1;
        tx_data    = fifo_dout;
        if (fifo_empty) begin
          // Starved: hold state and counter, flag it for software.
          underrun_d = 1'b1;
        end else begin
          tx_valid   = 1'b1;
          fifo_rd_en = tx_rdy;
`ifndef ADC_PKT_CHECKSUM_EN
          tx_last    = (pay_cnt_q == LAST_IDX);
`endif
          if (tx_rdy) begin
`ifdef ADC_PKT_CHECKSUM_EN
            csum_d = csum_q ^ fifo_dout;
`endif
            if (pay_cnt_q == LAST_IDX) begin
              pay_cnt_d = 16'd0;
`ifdef ADC_PKT_CHECKSUM_EN
              state_d   = S_TRAILER;
`else
              state_d   = S_GAP;
              gap_cnt_d = 8'd0;
              seq_d     = seq_q + 16'd1;
`endif
            end else begin
              pay_cnt_d = pay_cnt_q + 16'd1;
            end
          end
        end
      end

`ifdef ADC_PKT_CHECKSUM_EN
      S_TRAILER: begin
        pkt_active = 1'b1;
        tx_valid   = 1'b1;
        tx_data    = csum_q;
        tx_last    = 1'b1;
        if (tx_rdy) begin
          state_d   = S_GAP;
          gap_cnt_d = 8'd0;
          seq_d     = seq_q + 16'd1;
        end
      end
`endif

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = S_IDLE;
          gap_cnt_d = 8'd0;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      hdr_idx_q  <= 3'd0;
      pay_cnt_q  <= 16'd0;
      gap_cnt_q  <= 8'd0;
      seq_q      <= 16'd0;
      underrun_q <= 1'b0;
`ifdef ADC_PKT_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      hdr_idx_q  <= hdr_idx_d;
      pay_cnt_q  <= pay_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      seq_q      <= seq_d;
      underrun_q <= underrun_d;
`ifdef ADC_PKT_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule
